// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: request ports of both masters plus the single-port data memory bus
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          p0_req;
  logic          p0_we;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_wdata;
  logic          p0_gnt;
  logic          p0_stall;
  logic          p0_rvalid;
  logic [DW-1:0] p0_rdata;
  logic          p1_req;
  logic          p1_we;
  logic          p1_lock;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p1_wdata;
  logic          p1_gnt;
  logic          p1_rvalid;
  logic [DW-1:0] p1_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;
  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata, p1_req, p1_we, p1_lock, p1_addr, p1_wdata, mem_rd,
    output p0_gnt, p0_stall, p0_rvalid, p0_rdata, p1_gnt, p1_rvalid, p1_rdata, mem_we, mem_addr, mem_wd
  );
  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata, p1_req, p1_we, p1_lock, p1_addr, p1_wdata, mem_rd,
    input  p0_gnt, p0_stall, p0_rvalid, p0_rdata, p1_gnt, p1_rvalid, p1_rdata, mem_we, mem_addr, mem_wd
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter for the data memory; port 0 has priority, port 1 has anti-starvation and burst lock
module dmem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_WAIT  = 4,
  parameter int BURST_MAX = 8
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int BW = $clog2(BURST_MAX + 1);
  typedef enum logic {IDLE, OWN1} state_t;
  state_t        state, state_nxt;
  logic [WW-1:0] wait_cnt;
  logic [BW-1:0] burst_cnt, burst_nxt, burst_inc;
  logic          g0, g1;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      burst_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_nxt;
      wait_cnt  <= (bus.p1_req && !g1) ? ((wait_cnt == WW'(MAX_WAIT)) ? wait_cnt : wait_cnt + WW'(1)) : '0;
    end
  end
  // burst_cnt counts grants already taken under the current lock
  always_comb begin
    burst_inc = burst_cnt + BW'(1);
    state_nxt = IDLE;
    burst_nxt = '0;
    if (state == IDLE && g1 && bus.p1_lock && BURST_MAX > 1) begin
      state_nxt = OWN1;
      burst_nxt = BW'(1);
    end else if (state == OWN1 && g1 && bus.p1_lock && burst_inc < BW'(BURST_MAX)) begin
      state_nxt = OWN1;
      burst_nxt = burst_inc;
    end
  end
  always_comb begin
    g1 = !rst && bus.p1_req && (state == OWN1 || !bus.p0_req || wait_cnt == WW'(MAX_WAIT));
    g0 = !rst && state == IDLE && bus.p0_req && !g1;
  end
  assign bus.p0_gnt   = g0;
  assign bus.p1_gnt   = g1;
  assign bus.p0_stall = bus.p0_req && !g0;
  assign bus.mem_we   = g0 ? bus.p0_we    : g1 ? bus.p1_we    : 1'b0;
  assign bus.mem_addr = g0 ? bus.p0_addr  : g1 ? bus.p1_addr  : '0;
  assign bus.mem_wd   = g0 ? bus.p0_wdata : g1 ? bus.p1_wdata : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.p0_rvalid <= 1'b0;
      bus.p1_rvalid <= 1'b0;
      bus.p0_rdata  <= '0;
      bus.p1_rdata  <= '0;
    end else begin
      bus.p0_rvalid <= g0 && !bus.p0_we;
      bus.p1_rvalid <= g1 && !bus.p1_we;
      if (g0 && !bus.p0_we) bus.p0_rdata <= bus.mem_rd;
      if (g1 && !bus.p1_we) bus.p1_rdata <= bus.mem_rd;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table-driven cycle vectors with a read-return scoreboard against a shadow memory
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  dmem_arbiter_if #(.AW(32), .DW(32)) bus ();
  dmem_arbiter #(.AW(32), .DW(32), .MAX_WAIT(4), .BURST_MAX(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic rst, p0r, p0w;
    logic [31:0] p0a, p0d;
    logic p1r, p1w, p1l;
    logic [31:0] p1a, p1d;
    logic e0, e1;
  } vec_t;
  typedef struct {
    logic [31:0] data;
    int cyc;
  } sb_t;
  vec_t tbl[$];
  sb_t q[2][$];
  sb_t se;
  logic [31:0] mem [256];
  logic [31:0] sh [256];
  logic [31:0] last [2];
  int vectors = 0, miscompares = 0, cyc = 0;
  logic rs;
  assign bus.mem_rd = mem[bus.mem_addr[7:0]];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wd;
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, e, cyc);
    end
  endtask
  function automatic void v(logic r, logic p0r, logic p0w, logic [31:0] p0a, logic [31:0] p0d,
                            logic p1r, logic p1w, logic p1l, logic [31:0] p1a, logic [31:0] p1d,
                            logic e0, logic e1);
    tbl.push_back('{r, p0r, p0w, p0a, p0d, p1r, p1w, p1l, p1a, p1d, e0, e1});
  endfunction
  task automatic apply(vec_t t);
    @(negedge clk);
    rst = t.rst;
    bus.p0_req = t.p0r; bus.p0_we = t.p0w; bus.p0_addr = t.p0a; bus.p0_wdata = t.p0d;
    bus.p1_req = t.p1r; bus.p1_we = t.p1w; bus.p1_lock = t.p1l; bus.p1_addr = t.p1a; bus.p1_wdata = t.p1d;
    #2;
    chk("p0_gnt", bus.p0_gnt, t.e0);
    chk("p1_gnt", bus.p1_gnt, t.e1);
    chk("p0_stall", bus.p0_stall, t.p0r & ~t.e0);
    chk("mem_we", bus.mem_we, t.e0 ? t.p0w : t.e1 ? t.p1w : 1'b0);
    chk("mem_addr", bus.mem_addr, t.e0 ? t.p0a : t.e1 ? t.p1a : 32'h0);
    chk("mem_wd", bus.mem_wd, t.e0 ? t.p0d : t.e1 ? t.p1d : 32'h0);
    if (t.e0 && !t.p0w) q[0].push_back('{sh[t.p0a[7:0]], cyc + 1});
    if (t.e1 && !t.p1w) q[1].push_back('{sh[t.p1a[7:0]], cyc + 1});
    if (t.e0 && t.p0w) sh[t.p0a[7:0]] = t.p0d;
    if (t.e1 && t.p1w) sh[t.p1a[7:0]] = t.p1d;
  endtask
  // read-return monitor: every rvalid must match a queued grant from exactly one cycle earlier
  always @(posedge clk) begin
    cyc++;
    rs = rst;
    #1;
    if (rs) begin
      last[0] = 32'h0;
      last[1] = 32'h0;
    end
    for (int p = 0; p < 2; p++) begin
      logic rv;
      logic [31:0] rd;
      rv = p ? bus.p1_rvalid : bus.p0_rvalid;
      rd = p ? bus.p1_rdata : bus.p0_rdata;
      if (rv && !rs && q[p].size() != 0) begin
        se = q[p].pop_front();
        chk(p ? "p1_rvalid cycle" : "p0_rvalid cycle", cyc, se.cyc);
        chk(p ? "p1_rdata" : "p0_rdata", rd, se.data);
        last[p] = se.data;
      end else if (rv) chk(p ? "p1_rvalid spurious" : "p0_rvalid spurious", rv, 1'b0);
      else if (!rs) chk(p ? "p1_rdata hold" : "p0_rdata hold", rd, last[p]);
    end
  end
  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 32'h0;
      sh[i] = 32'h0;
    end
    last[0] = 32'h0; last[1] = 32'h0;
    bus.p0_req = 0; bus.p0_we = 0; bus.p0_addr = 0; bus.p0_wdata = 0;
    bus.p1_req = 0; bus.p1_we = 0; bus.p1_lock = 0; bus.p1_addr = 0; bus.p1_wdata = 0;
    // reset with both requesting
    v(1, 1,0,'h10,0,         1,0,0,'h21,0,      0,0);
    v(1, 1,0,'h10,0,         1,0,0,'h21,0,      0,0);
    // starvation: p0 wins four times, p1 on the fifth, then wait count restarts
    v(0, 1,1,'h20,'hA0,      1,0,0,'h21,0,      1,0);
    v(0, 1,1,'h21,'hB1,      1,0,0,'h21,0,      1,0);
    v(0, 1,1,'h22,'hC2,      1,0,0,'h21,0,      1,0);
    v(0, 1,1,'h23,'hD3,      1,0,0,'h21,0,      1,0);
    v(0, 1,0,'h20,0,         1,0,0,'h21,0,      0,1);
    v(0, 1,0,'h20,0,         1,0,0,'h22,0,      1,0);
    v(0, 1,0,'h23,0,         0,0,0,0,0,         1,0);
    // single-port paths
    v(0, 1,1,'h10,'hDEADBEEF,0,0,0,0,0,         1,0);
    v(0, 1,0,'h10,0,         0,0,0,0,0,         1,0);
    v(0, 0,0,0,0,            1,1,0,'h30,'h1234, 0,1);
    v(0, 0,0,0,0,            1,0,0,'h30,0,      0,1);
    v(0, 0,0,0,0,            0,0,0,0,0,         0,0);
    // full locked burst, p0 shut out until the ninth cycle
    v(0, 0,0,0,0,            1,0,1,'h20,0,      0,1);
    for (int i = 1; i < 8; i++) v(0, 1,0,'h10,0, 1,0,1,32'h20 + i,0, 0,1);
    v(0, 1,0,'h10,0,         1,0,1,'h28,0,      1,0);
    v(0, 0,0,0,0,            1,0,0,'h28,0,      0,1);
    v(0, 0,0,0,0,            0,0,0,0,0,         0,0);
    // early unlock on the third access
    v(0, 0,0,0,0,            1,0,1,'h20,0,      0,1);
    v(0, 1,0,'h22,0,         1,0,1,'h21,0,      0,1);
    v(0, 1,0,'h22,0,         1,0,0,'h22,0,      0,1);
    v(0, 1,0,'h22,0,         1,0,0,'h23,0,      1,0);
    v(0, 0,0,0,0,            1,0,0,'h23,0,      0,1);
    // p1 drops its request while owning the memory
    v(0, 0,0,0,0,            1,0,1,'h24,0,      0,1);
    v(0, 1,1,'h50,'h55,      0,0,1,0,0,         0,0);
    v(0, 1,1,'h50,'h55,      0,0,0,0,0,         1,0);
    v(0, 1,0,'h50,0,         0,0,0,0,0,         1,0);
    v(0, 0,0,0,0,            0,0,0,0,0,         0,0);
    foreach (tbl[i]) apply(tbl[i]);
    // reset lands on the fourth locked grant; the lock is abandoned
    apply('{0, 0,0,0,0,           1,0,1,'h20,0, 0,1});
    apply('{0, 1,0,'h21,0,        1,0,1,'h21,0, 0,1});
    apply('{0, 1,0,'h21,0,        1,0,1,'h22,0, 0,1});
    apply('{1, 1,1,'h60,'h66,     1,0,1,'h23,0, 0,0});
    apply('{0, 1,1,'h60,'h66,     1,0,1,'h23,0, 1,0});
    apply('{0, 1,0,'h60,0,        1,0,1,'h23,0, 1,0});
    apply('{0, 0,0,0,0,           1,0,0,'h23,0, 0,1});
    apply('{0, 0,0,0,0,           0,0,0,0,0,    0,0});
    apply('{0, 0,0,0,0,           0,0,0,0,0,    0,0});
    chk("p0 reads outstanding", q[0].size(), 0);
    chk("p1 reads outstanding", q[1].size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
